pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Fetch-side control that consumes the ID-stage comparator result (cmp_zero) and owns the program counter.
//   - Holds the architectural F-stage PC.
//   - Holds the IF/ID pipeline register (instr_d, pc_d, pc8_d).
//   - Resolves beq/bne/j/jal/jr in ID and selects next PC, with one MIPS branch delay slot.
//   - Sits between instruction memory (IM) and the ID-stage decoder/comparator.
// PARAMETERS
//   PC_RESET   32'h0000_3000   PC value loaded on reset (first fetch address)
//   INSTR_NOP  32'h0000_0000   instr_d value after reset (sll $0,$0,0)
// PORTS
//   clk        in   1    single clock, all state updates on posedge
//   reset      in   1    synchronous, active-high
//   stall      in   1    from hazard unit; freeze PC and IF/ID
//   instr_f    in   32   instruction read from IM at pc_f
//   br_op      in   3    ID-stage decoded op: 0 NONE, 1 BEQ, 2 BNE, 3 J, 4 JAL, 5 JR, 6-7 = NONE
//   cmp_zero   in   1    ID comparator output: 1 when forwarded rs == forwarded rt
//   rs_fwd_d   in   32   forwarded rs value in ID (jr target)
//   pc_f       out  32   current fetch address to IM
//   instr_d    out  32   IF/ID instruction
//   pc_d       out  32   IF/ID PC
//   pc8_d      out  32   pc_d + 8, link value for jal
// BEHAVIOUR
//   Reset (reset=1 at posedge):
//   - pc_f <= PC_RESET, instr_d <= INSTR_NOP, pc_d <= PC_RESET - 4.
//   - reset overrides stall and any br_op.
//   pc8_d: combinational pc_d + 8.
//   Stall (stall=1, reset=0): pc_f, instr_d, pc_d hold. br_op is evaluated but not committed.
//   Normal (stall=0): instr_d <= instr_f; pc_d <= pc_f; pc_f <= npc.
//   npc, combinational from ID-stage state (imm16 = instr_d[15:0]):
//   - NONE:  pc_f + 4
//   - BEQ:   cmp_zero ? pc_d + 4 + (sext(imm16) << 2) : pc_f + 4
//   - BNE:   !cmp_zero ? pc_d + 4 + (sext(imm16) << 2) : pc_f + 4
//   - J/JAL: {pc_d[31:28], instr_d[25:0], 2'b00}
//   - JR:    rs_fwd_d, passed unchanged (no alignment masking)
//   Delay slot:
//   - The instruction at pc_d + 4 is already in F when the branch resolves.
//   - It is always captured into IF/ID and executed. No flush output exists.
//   Latency: a taken redirect appears on pc_f one cycle after the branch occupies ID with stall=0.
//   Arithmetic: all adds are 32-bit modulo; pc_f = 0xFFFF_FFFC wraps to 0x0000_0000 on +4.
//   Branch during stall: the redirect is taken on the first cycle stall drops. cmp_zero/rs_fwd_d are sampled then.
//   Reset mid-stall or mid-branch: the redirect is discarded; fetch restarts at PC_RESET.
//   No internal FSM beyond these registers; the design is fully deterministic from state + inputs.
// TESTING
//   1. reset 2 cycles then release, br_op=0, instr_f fixed -> pc_f 0x3000, 0x3004, 0x3008; pc_d trails pc_f by one cycle.
//   2. beq in ID at pc_d=0x3010, imm16=0x0003, cmp_zero=1 ->
//      - next pc_f = 0x3020;
//      - delay slot 0x3014 captured into instr_d;
//      - with cmp_zero=0 -> next pc_f = 0x3018.
//   3. bne, pc_d=0x3040, imm16=0xFFFE, cmp_zero=0 -> next pc_f = 0x303C (negative offset).
//   4. jal at pc_d=0x3000, instr_d[25:0]=0x0000C10 -> next pc_f = 0x3040 (target field x4), pc8_d = 0x3008.
//      jr with rs_fwd_d = 0x0000_3ABC -> next pc_f = 0x3ABC.
//   5. stall=1 for 3 cycles while beq (taken) in ID ->
//      - pc_f/instr_d/pc_d frozen;
//      - the cycle after stall drops, pc_f = target;
//      - reset asserted during the stall -> pc_f = 0x3000, instr_d = 0.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Fetch-side bundle between the hazard unit, instruction memory, the ID-stage
// decoder/comparator and the fetch unit that owns the PC and the IF/ID register.
interface pc_fetch_if;
    logic        stall;
    logic [31:0] instr_f;
    logic [2:0]  br_op;
    logic        cmp_zero;
    logic [31:0] rs_fwd_d;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;

    // The side that feeds the fetch unit: IM, decoder, comparator, hazard unit.
    modport master (
        output stall,
        output instr_f,
        output br_op,
        output cmp_zero,
        output rs_fwd_d,
        input  pc_f,
        input  instr_d,
        input  pc_d,
        input  pc8_d
    );

    modport slave (
        input  stall,
        input  instr_f,
        input  br_op,
        input  cmp_zero,
        input  rs_fwd_d,
        output pc_f,
        output instr_d,
        output pc_d,
        output pc8_d
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and IF/ID register; branches and jumps resolve in ID and
// redirect fetch one cycle later, always keeping the single delay slot.
module pc_fetch_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] INSTR_NOP = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      reset,
    pc_fetch_if.slave bus
);

    localparam logic [2:0] OP_BEQ = 3'd1;
    localparam logic [2:0] OP_BNE = 3'd2;
    localparam logic [2:0] OP_J   = 3'd3;
    localparam logic [2:0] OP_JAL = 3'd4;
    localparam logic [2:0] OP_JR  = 3'd5;

    logic [31:0] pc_f_q;
    logic [31:0] instr_d_q;
    logic [31:0] pc_d_q;

    logic [31:0] seq_pc;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] jump_target;
    logic [31:0] npc;

    assign seq_pc      = pc_f_q + 32'd4;
    assign br_offset   = {{14{instr_d_q[15]}}, instr_d_q[15:0], 2'b00};
    assign br_target   = pc_d_q + 32'd4 + br_offset;
    assign jump_target = {pc_d_q[31:28], instr_d_q[25:0], 2'b00};

    // Any unused op encoding falls through as sequential fetch.
    always_comb begin
        npc = seq_pc;
        case (bus.br_op)
            OP_BEQ:         npc = bus.cmp_zero ? br_target : seq_pc;
            OP_BNE:         npc = bus.cmp_zero ? seq_pc : br_target;
            OP_J, OP_JAL:   npc = jump_target;
            OP_JR:          npc = bus.rs_fwd_d;
            default:        npc = seq_pc;
        endcase
    end

    // A stall simply withholds the commit; the pending op is re-evaluated
    // with fresh comparator/forwarding values on the cycle it drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q    <= PC_RESET;
            instr_d_q <= INSTR_NOP;
            pc_d_q    <= PC_RESET - 32'd4;
        end else if (!bus.stall) begin
            pc_f_q    <= npc;
            instr_d_q <= bus.instr_f;
            pc_d_q    <= pc_f_q;
        end
    end

    assign bus.pc_f    = pc_f_q;
    assign bus.instr_d = instr_d_q;
    assign bus.pc_d    = pc_d_q;
    assign bus.pc8_d   = pc_d_q + 32'd8;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed branch/jump/stall scenarios plus a random
// run, all compared against a small arithmetic model of the fetch pipeline.
module tb_pc_fetch_unit;

    localparam logic [31:0] PC_RST = 32'h0000_3000;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    logic [31:0] m_pc_f;
    logic [31:0] m_instr_d;
    logic [31:0] m_pc_d;

    pc_fetch_if bus ();

    pc_fetch_unit #(.PC_RESET(PC_RST), .INSTR_NOP(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next fetch address straight from the architectural rules.
    function automatic logic [31:0] ref_npc(input logic [2:0] op, input logic cz,
                                            input logic [31:0] rs);
        int          offset;
        logic [31:0] seq;
        logic [31:0] taken;
        seq    = m_pc_f + 32'd4;
        offset = int'($signed(m_instr_d[15:0])) * 4;
        taken  = m_pc_d + 32'd4 + offset;
        case (op)
            3'd1:    return cz ? taken : seq;
            3'd2:    return cz ? seq : taken;
            3'd3,
            3'd4:    return (m_pc_d & 32'hF000_0000) | (32'(m_instr_d[25:0]) << 2);
            3'd5:    return rs;
            default: return seq;
        endcase
    endfunction

    // One clock with model update; leaves time at posedge + 1.
    task automatic step();
        logic [31:0] nx;
        nx = ref_npc(bus.br_op, bus.cmp_zero, bus.rs_fwd_d);
        @(posedge clk);
        if (reset) begin
            m_pc_f    = PC_RST;
            m_instr_d = 32'h0;
            m_pc_d    = PC_RST - 32'd4;
        end else if (!bus.stall) begin
            m_instr_d = bus.instr_f;
            m_pc_d    = m_pc_f;
            m_pc_f    = nx;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall    = 1'b0;
        bus.br_op    = 3'd0;
        bus.cmp_zero = 1'b0;
        bus.rs_fwd_d = 32'h0;
        bus.instr_f  = 32'h0000_0000;
    endtask

    // Reset, then fetch sequentially until pc_f reaches addr (bounded).
    task automatic run_to(input logic [31:0] addr);
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 64 && bus.pc_f !== addr; i++) step();
        n_total++;
        if (bus.pc_f !== addr)
            $display("FAIL run_to: pc_f=%h required %h", bus.pc_f, addr);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        n_total++;
        if ({bus.pc_f, bus.instr_d, bus.pc_d, bus.pc8_d} !==
            {32'h3000, 32'h0, 32'h2FFC, 32'h3004})
            $display("FAIL reset_state: pc_f=%h instr_d=%h pc_d=%h pc8_d=%h required 3000/0/2ffc/3004",
                     bus.pc_f, bus.instr_d, bus.pc_d, bus.pc8_d);
        else n_pass++;
        reset = 1'b0;
        bus.instr_f = 32'h2408_0001;
        for (int i = 1; i <= 2; i++) begin
            step();
            n_total++;
            if (bus.pc_f !== PC_RST + 32'(4 * i) || bus.pc_d !== PC_RST + 32'(4 * (i - 1)))
                $display("FAIL sequential_%0d: pc_f=%h pc_d=%h required %h/%h", i, bus.pc_f,
                         bus.pc_d, PC_RST + 32'(4 * i), PC_RST + 32'(4 * (i - 1)));
            else n_pass++;
        end
    endtask

    task automatic test_beq(input logic cz, input logic [31:0] want);
        run_to(32'h3010);
        bus.instr_f = 32'h1000_0003;
        step();
        bus.br_op    = 3'd1;
        bus.cmp_zero = cz;
        bus.instr_f  = 32'hAAAA_3014;
        step();
        n_total++;
        if (bus.pc_f !== want || bus.instr_d !== 32'hAAAA_3014 || bus.pc_d !== 32'h3014)
            $display("FAIL beq_cz%0d: pc_f=%h instr_d=%h pc_d=%h required %h/aaaa3014/3014",
                     cz, bus.pc_f, bus.instr_d, bus.pc_d, want);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_bne_negative();
        run_to(32'h3040);
        bus.instr_f = 32'h1400_FFFE;
        step();
        bus.br_op    = 3'd2;
        bus.cmp_zero = 1'b0;
        step();
        n_total++;
        if (bus.pc_f !== 32'h303C)
            $display("FAIL bne_negative: pc_f=%h required 0000303c", bus.pc_f);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_jumps();
        run_to(32'h3000);
        bus.instr_f = 32'h0C00_0C10;
        step();
        n_total++;
        if (bus.pc8_d !== 32'h3008)
            $display("FAIL jal_link: pc8_d=%h required 00003008", bus.pc8_d);
        else n_pass++;
        bus.br_op = 3'd4;
        step();
        n_total++;
        if (bus.pc_f !== 32'h3040)
            $display("FAIL jal_target: pc_f=%h required 00003040", bus.pc_f);
        else n_pass++;
        bus.br_op    = 3'd5;
        bus.rs_fwd_d = 32'h0000_3ABC;
        step();
        n_total++;
        if (bus.pc_f !== 32'h3ABC)
            $display("FAIL jr_target: pc_f=%h required 00003abc", bus.pc_f);
        else n_pass++;
        bus.rs_fwd_d = 32'hFFFF_FFFC;
        step();
        bus.br_op = 3'd0;
        step();
        n_total++;
        if (bus.pc_f !== 32'h0)
            $display("FAIL pc_wrap: pc_f=%h required 00000000", bus.pc_f);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_stall_branch();
        run_to(32'h3010);
        bus.instr_f = 32'h1000_0003;
        step();
        bus.br_op    = 3'd1;
        bus.stall    = 1'b1;
        bus.instr_f  = 32'hBBBB_0000;
        for (int i = 0; i < 3; i++) begin
            bus.cmp_zero = (i != 1);
            step();
            n_total++;
            if ({bus.pc_f, bus.instr_d, bus.pc_d} !== {32'h3014, 32'h1000_0003, 32'h3010})
                $display("FAIL stall_freeze_%0d: pc_f=%h instr_d=%h pc_d=%h required 3014/10000003/3010",
                         i, bus.pc_f, bus.instr_d, bus.pc_d);
            else n_pass++;
        end
        bus.stall    = 1'b0;
        bus.cmp_zero = 1'b1;
        step();
        n_total++;
        if (bus.pc_f !== 32'h3020 || bus.instr_d !== 32'hBBBB_0000)
            $display("FAIL stall_release: pc_f=%h instr_d=%h required 3020/bbbb0000",
                     bus.pc_f, bus.instr_d);
        else n_pass++;

        run_to(32'h3010);
        bus.instr_f = 32'h1000_0003;
        step();
        bus.br_op    = 3'd1;
        bus.cmp_zero = 1'b1;
        bus.stall    = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_total++;
        if (bus.pc_f !== 32'h3000 || bus.instr_d !== 32'h0)
            $display("FAIL reset_in_stall: pc_f=%h instr_d=%h required 3000/0", bus.pc_f, bus.instr_d);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bus.stall    = ($urandom_range(0, 3) == 0);
            bus.br_op    = 3'($urandom_range(0, 7));
            bus.cmp_zero = 1'($urandom_range(0, 1));
            bus.rs_fwd_d = $urandom();
            if ($urandom_range(0, 1) == 1) bus.rs_fwd_d[1:0] = 2'b00;
            bus.instr_f  = $urandom();
            reset        = ($urandom_range(0, 49) == 0);
            step();
            n_total++;
            if ({bus.pc_f, bus.instr_d, bus.pc_d, bus.pc8_d} !==
                {m_pc_f, m_instr_d, m_pc_d, m_pc_d + 32'd8}) begin
                if (errs < 10)
                    $display("FAIL random_%0d: pc_f=%h instr_d=%h pc_d=%h pc8_d=%h required %h/%h/%h/%h",
                             i, bus.pc_f, bus.instr_d, bus.pc_d, bus.pc8_d,
                             m_pc_f, m_instr_d, m_pc_d, m_pc_d + 32'd8);
                errs++;
            end else n_pass++;
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        m_pc_f    = PC_RST;
        m_instr_d = 32'h0;
        m_pc_d    = PC_RST - 32'd4;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_beq(1'b1, 32'h3020);
        test_beq(1'b0, 32'h3018);
        test_bne_negative();
        test_jumps();
        test_stall_branch();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
